// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb_pkg.sv
// Shared arbitration types and helpers for the three-requester round-robin arbiter.
// Contents:
//   arb_state_e  - arbiter state encoding (IDLE=0, GRANT=1)
//   arb_idx_t    - requester index, 1..3 (0 means "no requester")
//   arb_next_idx - successor index with wrap 3->1
//   arb_onehot   - index to one-hot request/grant vector (bit 0 = requester 1)
//   arb_pick     - first requesting index in search order starting at a given index
package gf180mcu_fd_sc_mcu7t5v0__arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  typedef logic [1:0] arb_idx_t;

  localparam arb_idx_t IDX_NONE  = 2'd0;
  localparam arb_idx_t IDX_FIRST = 2'd1;
  localparam arb_idx_t IDX_LAST  = 2'd3;

  function automatic arb_idx_t arb_next_idx(input arb_idx_t idx);
    arb_idx_t nxt;
    if (idx == IDX_LAST) begin
      nxt = IDX_FIRST;
    end else begin
      nxt = idx + 2'd1;
    end
    return nxt;
  endfunction

  function automatic logic [2:0] arb_onehot(input arb_idx_t idx);
    logic [2:0] vec;
    case (idx)
      2'd1:    vec = 3'b001;
      2'd2:    vec = 3'b010;
      2'd3:    vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

  // Walks the three indices starting at 'start'; the first hit wins.
  function automatic arb_idx_t arb_pick(input logic [2:0] req, input arb_idx_t start);
    arb_idx_t cand;
    arb_idx_t found;
    found = IDX_NONE;
    cand  = start;
    for (int i = 0; i < 3; i++) begin
      if ((found == IDX_NONE) && ((req & arb_onehot(cand)) != 3'b000)) begin
        found = cand;
      end else begin
        found = found;
      end
      cand = arb_next_idx(cand);
    end
    return found;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or3_4_func.sv
// Functional model of the 3-input OR cell.
// Ports:
//   A1, A2, A3 - inputs
//   Z          - A1 | A2 | A3
module gf180mcu_fd_sc_mcu7t5v0__or3_4_func (
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic Z
);

  assign Z = A1 | A2 | A3;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_4.sv
// Three-requester round-robin arbiter with bounded grant tenure.
// A holder keeps its grant while it requests; once it has held for MAX_HOLD
// cycles and someone else is waiting, the grant is moved on. The search for the
// next holder starts just after the previous holder, which gives round-robin order.
// Ports:
//   CLK        - clock, rising edge
//   RST        - asynchronous active-high reset
//   A1..A3     - level-held requests
//   G1..G3     - registered grants, one-hot or all-zero
//   Z          - combinational any-request indication
//   BUSY       - high while a grant is held
module gf180mcu_fd_sc_mcu7t5v0__rrarb3_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic G1,
  output logic G2,
  output logic G3,
  output logic Z,
  output logic BUSY
);

  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;

  localparam int               CNT_W   = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  arb_idx_t         ptr_q, ptr_d;
  arb_idx_t         hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       grant_q, grant_d;

  logic [2:0]       req_s;
  logic [2:0]       others_s;
  arb_idx_t         succ_s;

  assign req_s = {A3, A2, A1};

  gf180mcu_fd_sc_mcu7t5v0__or3_4_func u_any_req (
    .A1 (A1),
    .A2 (A2),
    .A3 (A3),
    .Z  (Z)
  );

  // Next-state: grant selection, handover, preemption and tenure counting.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    succ_s   = arb_next_idx(hold_q);
    others_s = req_s & ~arb_onehot(hold_q);
    case (state_q)
      ARB_IDLE: begin
        if (req_s != 3'b000) begin
          hold_d  = arb_pick(req_s, ptr_q);
          state_d = ARB_GRANT;
          cnt_d   = '0;
        end else begin
          hold_d  = IDX_NONE;
        end
      end
      ARB_GRANT: begin
        if ((req_s & arb_onehot(hold_q)) == 3'b000) begin
          // Holder released: hand straight over, or go idle if nobody waits.
          ptr_d = succ_s;
          cnt_d = '0;
          if (others_s != 3'b000) begin
            hold_d = arb_pick(others_s, succ_s);
          end else begin
            hold_d  = IDX_NONE;
            state_d = ARB_IDLE;
          end
        end else if ((cnt_q == CNT_MAX) && (others_s != 3'b000)) begin
          // Tenure exhausted with a waiter present: preempt the holder.
          ptr_d  = succ_s;
          cnt_d  = '0;
          hold_d = arb_pick(others_s, succ_s);
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        hold_d  = IDX_NONE;
        cnt_d   = '0;
      end
    endcase
    grant_d = arb_onehot(hold_d);
  end

  // State, pointer, holder, tenure counter and grant registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ARB_IDLE;
      ptr_q   <= IDX_FIRST;
      hold_q  <= IDX_NONE;
      cnt_q   <= '0;
      grant_q <= 3'b000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign G1   = grant_q[0];
  assign G2   = grant_q[1];
  assign G3   = grant_q[2];
  assign BUSY = (state_q == ARB_GRANT);

  specify
    (posedge CLK => (G1 : 1'b1)) = (1.0, 1.0);
    (posedge CLK => (G2 : 1'b1)) = (1.0, 1.0);
    (posedge CLK => (G3 : 1'b1)) = (1.0, 1.0);
    (posedge CLK => (BUSY : 1'b1)) = (1.0, 1.0);
    (RST => G1) = (1.0, 1.0);
    (RST => G2) = (1.0, 1.0);
    (RST => G3) = (1.0, 1.0);
    (RST => BUSY) = (1.0, 1.0);
    (A1 => Z) = (1.0, 1.0);
    (A2 => Z) = (1.0, 1.0);
    (A3 => Z) = (1.0, 1.0);
  endspecify

endmodule
